// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry and line levels.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    localparam int   UART_DATA_BITS   = 8;
    localparam logic UART_START_LEVEL = 1'b0;
    localparam logic UART_STOP_LEVEL  = 1'b1;
    localparam logic UART_IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_tx_byte_fifo.sv
// Generic synchronous FIFO, power-of-two depth, head entry visible on pop_dat_o.
// Latency: a pushed entry is visible (count/empty) the cycle after the push edge.
// Backpressure: full_o high refuses pushes; pushes while full and pops while empty are ignored.
// Ports: clk/resetn, push_i+push_dat_i, pop_i+pop_dat_o, count_o, full_o, empty_o.
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_dat_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign pop_dat_o = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read when count says they are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding an LSB-first serialiser with back-to-back frames.
// Latency: byte accepted at edge E is popped at E+1; txd_o falls after E+1; frame is 10*CLKS_PER_BIT cycles.
// Backpressure: tx_ready_o low while the FIFO is full; no push occurs until a frame start frees a slot.
// Ports: clk/resetn, tx_data_i/tx_valid_i/tx_ready_o, txd_o, busy_o, fifo_count_o.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [7:0]                    tx_data_i,
    input  logic                          tx_valid_i,
    output logic                          tx_ready_o,
    output logic                          txd_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(UART_DATA_BITS);
    localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_BIT  = IW'(UART_DATA_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx: CLKS_PER_BIT must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
        $error("uart_tx: FIFO_DEPTH must be a power of two and at least 2");
    end

    uart_tx_state_t            state_q, state_d;
    logic [BW-1:0]             baud_q, baud_d;
    logic [IW-1:0]             bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      txd_q, txd_d;

    logic                      fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]                fifo_dat;
    logic                      bit_done;

    assign tx_ready_o = !fifo_full;
    assign fifo_push  = tx_valid_i && tx_ready_o;
    assign bit_done   = (baud_q == '0);
    assign busy_o     = (state_q != IDLE) || !fifo_empty;
    assign txd_o      = txd_q;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push_i     (fifo_push),
        .push_dat_i (tx_data_i),
        .pop_i      (fifo_pop),
        .pop_dat_o  (fifo_dat),
        .count_o    (fifo_count_o),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;
        txd_d     = UART_IDLE_LEVEL;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dat;
                    baud_d   = BAUD_LOAD;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_done) begin
                    baud_d    = BAUD_LOAD;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    baud_d    = BAUD_LOAD;
                    shift_d   = {1'b0, shift_q[UART_DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + IW'(1);
                    if (bit_idx_q == LAST_BIT) state_d = STOP;
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            STOP: begin
                if (bit_done) begin
                    // Chain straight into the next frame so queued bytes leave no idle gap.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dat;
                        baud_d   = BAUD_LOAD;
                        state_d  = START;
                    end else begin
                        state_d  = IDLE;
                    end
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // The line level is registered from the next state so it changes on the same edge as the FSM.
        case (state_d)
            START:   txd_d = UART_START_LEVEL;
            DATA:    txd_d = shift_d[0];
            STOP:    txd_d = UART_STOP_LEVEL;
            default: txd_d = UART_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= UART_IDLE_LEVEL;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Outputs sampled on falling edges; inputs driven on falling edges.
// Serial line decoded at mid-bit, one sample per 4 clocks.
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       txd;
    logic       busy;
    logic [2:0] fifo_count;

    int tests    = 0;
    int fails    = 0;
    int timeouts = 0;
    int bad      = 0;
    int w        = 0;
    int maxc     = 0;

    logic [7:0] rxb [9];

    always #5 clk = ~clk;

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .tx_data_i    (tx_data),
        .tx_valid_i   (tx_valid),
        .tx_ready_o   (tx_ready),
        .txd_o        (txd),
        .busy_o       (busy),
        .fifo_count_o (fifo_count)
    );

    always @(negedge clk) begin
        if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Holds tx_valid high until the byte is accepted; returns on the falling edge after acceptance.
    task automatic push_byte(input logic [7:0] b, output int waited);
        tx_data  = b;
        tx_valid = 1'b1;
        waited   = 0;
        while (!tx_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) timeouts++;
        @(negedge clk);
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (txd !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_start_seen"}, 32'(n < 300), 1);
    endtask

    // Entered on the first falling edge that shows the start bit; exits on the stop-bit sample.
    task automatic rx_frame(input string tag, output logic [7:0] b);
        @(negedge clk);
        check({tag, "_startbit"}, txd, 0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = txd;
        end
        repeat (CPB) @(negedge clk);
        check({tag, "_stopbit"}, txd, 1);
    endtask

    task automatic gap0(input string tag);
        repeat (3) @(negedge clk);
        check({tag, "_no_gap"}, txd, 0);
    endtask

    task automatic frame_end(input string tag);
        repeat (2) @(negedge clk);
        check({tag, "_busy_in_stop"}, busy, 1);
        @(negedge clk);
        check({tag, "_busy_low"}, busy, 0);
        check({tag, "_line_idle"}, txd, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        resetn   = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_txd", txd, 1);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_count", fifo_count, 0);
        resetn = 1'b1;

        // Idle line after reset
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) bad++;
        end
        check("idle_bad_cycles", bad, 0);

        // Single byte 0xA5
        push_byte(8'hA5, w);
        tx_valid = 1'b0;
        check("single_count_after_push", fifo_count, 1);
        check("single_txd_before_pop", txd, 1);
        @(negedge clk);
        check("single_txd_fall", txd, 0);
        check("single_count_after_pop", fifo_count, 0);
        check("single_busy", busy, 1);
        rx_frame("single", b);
        check("single_byte", b, 8'hA5);
        frame_end("single");

        // Back-to-back 0x00, 0xFF, 0x55
        fork
            begin
                push_byte(8'h00, w);
                push_byte(8'hFF, w);
                push_byte(8'h55, w);
                tx_valid = 1'b0;
            end
            begin
                wait_start("b2b");
                rx_frame("b2b0", rxb[0]);
                gap0("b2b0");
                rx_frame("b2b1", rxb[1]);
                gap0("b2b1");
                rx_frame("b2b2", rxb[2]);
                frame_end("b2b");
            end
        join
        check("b2b_byte0", rxb[0], 8'h00);
        check("b2b_byte1", rxb[1], 8'hFF);
        check("b2b_byte2", rxb[2], 8'h55);

        // Full FIFO with valid held high over 6 bytes
        fork
            begin
                for (int i = 0; i < 5; i++) push_byte(8'h40 + 8'(i), w);
                check("full_count", fifo_count, 4);
                check("full_ready_low", tx_ready, 0);
                push_byte(8'h45, w);
                tx_valid = 1'b0;
                check("full_ready_wait_cycles", w, 37);
                check("full_count_refilled", fifo_count, 4);
            end
            begin
                wait_start("full");
                for (int i = 0; i < 6; i++) begin
                    rx_frame("full", rxb[i]);
                    if (i < 5) gap0("full");
                end
                frame_end("full");
            end
        join
        for (int i = 0; i < 6; i++) check($sformatf("full_byte%0d", i), rxb[i], 32'h40 + 32'(i));

        // Reset during data bit 3 of 0x3C with two bytes queued
        push_byte(8'h3C, w);
        push_byte(8'h11, w);
        push_byte(8'h22, w);
        tx_valid = 1'b0;
        check("rstmid_count_queued", fifo_count, 2);
        repeat (16) @(negedge clk);
        check("rstmid_bit3", txd, 1);
        check("rstmid_busy", busy, 1);
        #1 resetn = 1'b0;
        #1;
        check("rstmid_txd", txd, 1);
        check("rstmid_count", fifo_count, 0);
        check("rstmid_ready", tx_ready, 1);
        check("rstmid_busy_low", busy, 0);
        @(negedge clk);
        resetn = 1'b1;
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) bad++;
        end
        check("rstmid_no_residual", bad, 0);

        // Pointer wrap: 9 bytes in bursts of 3
        maxc = 0;
        for (int k = 0; k < 3; k++) begin
            fork
                begin
                    for (int i = 0; i < 3; i++) push_byte(8'h10 + 8'(3 * k + i), w);
                    tx_valid = 1'b0;
                    check("wrap_count_after_burst", fifo_count, 2);
                end
                begin
                    wait_start("wrap");
                    rx_frame("wrap", rxb[3 * k]);
                    gap0("wrap");
                    rx_frame("wrap", rxb[3 * k + 1]);
                    gap0("wrap");
                    rx_frame("wrap", rxb[3 * k + 2]);
                    frame_end("wrap");
                end
            join
        end
        for (int i = 0; i < 9; i++) check($sformatf("wrap_byte%0d", i), rxb[i], 32'h10 + 32'(i));
        check("wrap_max_count", maxc, 2);

        check("push_timeouts", timeouts, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
